n64_pi_host: RTL and testbench
==============================

Name: n64_pi_host

Overview:
- Drives the N64 Parallel Interface as bus initiator (RCP side): ALEH/ALEL address phases, then READ/WRITE strobes carrying 16-bit halfwords on the AD bus.
- Used for on-board loopback self-test and simulation, where it exercises the cartridge-side PI target across the real pins.
- Converts a single internal request (address, word count, direction) into one full PI burst, exchanging 32-bit words with the internal side.

Parameters:
- T_ALE, 8: cycles each address phase (HIGH, LOW) is held; must be >= 4 to cover the target's 2-FF sync plus edge detect.
- T_SETTLE, 32: cycles in VALID mode before the first strobe; covers target bank decode and prefetch.
- T_STROBE_LOW, 8: cycles READ or WRITE is held low per halfword.
- T_STROBE_HIGH, 8: cycles READ or WRITE is held high between halfwords.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  synchronous, active-low reset
- i_request  in  1  start a burst; sampled only in IDLE
- i_write  in  1  burst direction: 1 = write, 0 = read
- i_address  in  32  PI byte address; bit 0 is forced to 0 on the bus
- i_length  in  8  number of 32-bit words minus 1 (range 1..256 words)
- o_busy  out  1  high from request acceptance until return to IDLE
- o_done  out  1  one-cycle pulse on return to IDLE
- i_data  in  32  write word; sampled in the cycle o_data_ack is high
- o_data_ack  out  1  write word consumed; upstream presents the next word by the following cycle
- o_data  out  32  assembled read word
- o_data_valid  out  1  one-cycle pulse when o_data holds a new read word
- o_n64_pi_aleh  out  1  address latch enable, high half
- o_n64_pi_alel  out  1  address latch enable, low half
- o_n64_pi_read  out  1  read strobe, active low
- o_n64_pi_write  out  1  write strobe, active low
- io_n64_pi_ad  inout  16  multiplexed address/data bus

Behaviour:
- Reset (i_reset_n=0 at a clock edge, including mid-burst): state IDLE; aleh=1, alel=0 (idle mode 10); read=1; write=1; AD=Z. o_busy, o_done, o_data_ack and o_data_valid are 0; o_data is 0.
- All PI pin outputs are registered and change only on state or counter transitions.
- States and sequence:
  - IDLE: mode 10, AD=Z. On i_request, capture address, length and direction; set o_busy; go to ADDR_HIGH.
  - ADDR_HIGH: mode 11, AD drives address[31:16], for T_ALE cycles.
  - ADDR_LOW: mode 01, AD drives {address[15:1],0}, for T_ALE cycles.
  - SETTLE: mode 00. For a read, AD=Z. For a write, AD drives the upper halfword of the first word. Lasts T_SETTLE cycles.
  - STROBE_LOW: the selected strobe is 0 for T_STROBE_LOW cycles.
  - STROBE_HIGH: the strobe is 1 for T_STROBE_HIGH cycles. Then either return to STROBE_LOW, or go to FINISH if this was the last halfword.
  - FINISH: mode 10, AD=Z, for T_ALE cycles. Then o_done pulses, o_busy clears, state returns to IDLE.
- Halfword order: big-endian; halfword 0 = bits [31:16], halfword 1 = bits [15:0]. A 1-bit halfword toggle and an 8-bit remaining-word counter track progress.
- Total strobes = 2*(i_length+1).
- Read path:
  - AD is sampled in the last cycle of STROBE_LOW.
  - Halfword 0 goes to a holding register.
  - On halfword 1, o_data = {hold, AD} and o_data_valid pulses in the next cycle.
  - The host never drives AD during a read burst.
- Write path:
  - o_data_ack pulses in the request-acceptance cycle; i_data is latched into the shift register in that same cycle.
  - AD is driven from the start of SETTLE until FINISH.
  - At the end of each halfword-1 STROBE_HIGH with words remaining, the next i_data is latched with an o_data_ack pulse.
  - Total acks = i_length+1.
- i_request while o_busy is ignored and does not queue.
- Word-counter wrap: i_length=255 yields exactly 256 words.
- Phase counters are sized to clog2(max parameter)+1 bits and count down to 0; each parameter is >= 1.

Decomposition:
- Shared package (n64_pi_pkg): PI mode constants IDLE=10, HIGH=11, LOW=01, VALID=00, and the host state enum.
- One natural sub-module, n64_pi_host_timer: loadable down-counter with a zero flag, shared by all phases.

Test Plan:
- Read, address 0x10000000, i_length=0 -> aleh/alel sequence 10,11,01,00; AD shows 0x1000 then 0x0000; exactly 2 READ pulses; target model returns 0xDEAD, 0xBEEF -> o_data=0xDEADBEEF with one o_data_valid pulse; o_done pulses once.
- Write, address 0x10000002, i_length=1, words 0x11223344, 0x55667788 -> low address phase shows 0x0002; 4 WRITE pulses carry 0x1122, 0x3344, 0x5566, 0x7788; exactly 2 o_data_ack pulses.
- Read with i_length=255 -> exactly 512 READ pulses and 256 o_data_valid pulses; the counter does not wrap early.
- i_request held high throughout a burst -> a second burst starts only after o_done, from IDLE.
- i_reset_n low during STROBE_LOW of word 3 -> next cycle: mode 10, read=1, AD=Z, o_busy=0; no o_done pulse.
- Address 0x10000001 -> AD low phase shows 0x0000 (bit 0 forced to 0).

Source files
------------

// File: rtl/n64_pi_pkg.sv
// Shared PI bus mode encodings and host FSM state type.
package n64_pi_pkg;

  // {aleh, alel} pin pairs
  localparam logic [1:0] MODE_IDLE  = 2'b10;
  localparam logic [1:0] MODE_HIGH  = 2'b11;
  localparam logic [1:0] MODE_LOW   = 2'b01;
  localparam logic [1:0] MODE_VALID = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HIGH,
    ST_ADDR_LOW,
    ST_SETTLE,
    ST_STROBE_LOW,
    ST_STROBE_HIGH,
    ST_FINISH
  } host_state_t;

  function automatic logic [1:0] state_mode(host_state_t s);
    case (s)
      ST_IDLE, ST_FINISH: state_mode = MODE_IDLE;
      ST_ADDR_HIGH:       state_mode = MODE_HIGH;
      ST_ADDR_LOW:        state_mode = MODE_LOW;
      default:            state_mode = MODE_VALID;
    endcase
  endfunction

endpackage

// File: rtl/n64_pi_host_if.sv
// Internal request/data handshake between an upstream client and the PI host.
interface n64_pi_host_if;
  logic        request;
  logic        write;
  logic [31:0] address;
  logic [7:0]  length;
  logic        busy;
  logic        done;
  logic [31:0] wdata;
  logic        data_ack;
  logic [31:0] rdata;
  logic        data_valid;

  modport master (
    output request, write, address, length, wdata,
    input  busy, done, data_ack, rdata, data_valid
  );

  modport slave (
    input  request, write, address, length, wdata,
    output busy, done, data_ack, rdata, data_valid
  );
endinterface

// File: rtl/n64_pi_host_timer.sv
// Loadable down-counter shared by every PI phase; o_zero marks the last cycle of a phase.
module n64_pi_host_timer #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)              r_count <= '0;
    else if (i_load)             r_count <= i_value;
    else if (r_count != '0)      r_count <= r_count - W'(1);
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/n64_pi_host.sv
// N64 PI bus initiator: turns one internal request into a full ALEH/ALEL + strobe burst.
//   state       | meaning
//   IDLE        | mode 10, AD released, waiting for request
//   ADDR_HIGH   | mode 11, AD = address[31:16]
//   ADDR_LOW    | mode 01, AD = {address[15:1],0}
//   SETTLE      | mode 00, target decode/prefetch time; writes drive first halfword
//   STROBE_LOW  | READ or WRITE low; read data sampled in last cycle
//   STROBE_HIGH | strobe high between halfwords
//   FINISH      | mode 10, AD released, then o_done
module n64_pi_host
  import n64_pi_pkg::*;
#(
  parameter int T_ALE         = 8,
  parameter int T_SETTLE      = 32,
  parameter int T_STROBE_LOW  = 8,
  parameter int T_STROBE_HIGH = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  n64_pi_host_if.slave      bus,
  output logic              o_n64_pi_aleh,
  output logic              o_n64_pi_alel,
  output logic              o_n64_pi_read,
  output logic              o_n64_pi_write,
  inout  wire  [15:0]       io_n64_pi_ad
);

  localparam int T_MAX_A = (T_ALE > T_SETTLE) ? T_ALE : T_SETTLE;
  localparam int T_MAX_B = (T_STROBE_LOW > T_STROBE_HIGH) ? T_STROBE_LOW : T_STROBE_HIGH;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int TW      = $clog2(T_MAX) + 1;

  host_state_t r_state, w_state_nx;
  logic [31:0] r_addr, w_addr_nx;
  logic [31:0] r_shift, w_shift_nx;
  logic [7:0]  r_words, w_words_nx;
  logic        r_half, w_half_nx;
  logic        r_write, w_write_nx;
  logic [15:0] r_hold;
  logic [31:0] r_rdata;
  logic        r_valid, r_done;
  logic        r_aleh, r_alel, r_read_n, r_write_n, r_ad_oe;
  logic [15:0] r_ad_out;

  logic          w_load, w_zero, w_ack, w_sample, w_finish;
  logic [TW-1:0] w_load_val;
  logic [1:0]    w_mode_nx;
  logic          w_strobe_nx, w_data_phase_nx, w_ad_oe_nx;
  logic [15:0]   w_ad_nx;

  n64_pi_host_timer #(.W(TW)) u_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_load    (w_load),
    .i_value   (w_load_val),
    .o_zero    (w_zero)
  );

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_addr_nx  = r_addr;
    w_write_nx = r_write;
    w_words_nx = r_words;
    w_half_nx  = r_half;
    w_shift_nx = r_shift;
    w_ack      = 1'b0;
    w_sample   = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.request) begin
        w_state_nx = ST_ADDR_HIGH;
        w_load     = 1'b1;
        w_load_val = TW'(T_ALE - 1);
        w_addr_nx  = bus.address & 32'hFFFF_FFFE;
        w_write_nx = bus.write;
        w_words_nx = bus.length;
        w_half_nx  = 1'b0;
        if (bus.write) begin
          w_ack      = 1'b1;
          w_shift_nx = bus.wdata;
        end
      end
      ST_ADDR_HIGH: if (w_zero) begin
        w_state_nx = ST_ADDR_LOW;
        w_load     = 1'b1;
        w_load_val = TW'(T_ALE - 1);
      end
      ST_ADDR_LOW: if (w_zero) begin
        w_state_nx = ST_SETTLE;
        w_load     = 1'b1;
        w_load_val = TW'(T_SETTLE - 1);
      end
      ST_SETTLE: if (w_zero) begin
        w_state_nx = ST_STROBE_LOW;
        w_load     = 1'b1;
        w_load_val = TW'(T_STROBE_LOW - 1);
      end
      ST_STROBE_LOW: if (w_zero) begin
        w_sample   = !r_write;
        w_state_nx = ST_STROBE_HIGH;
        w_load     = 1'b1;
        w_load_val = TW'(T_STROBE_HIGH - 1);
      end
      ST_STROBE_HIGH: if (w_zero) begin
        w_load = 1'b1;
        if (r_half && r_words == 8'd0) begin
          w_state_nx = ST_FINISH;
          w_load_val = TW'(T_ALE - 1);
        end else begin
          w_state_nx = ST_STROBE_LOW;
          w_load_val = TW'(T_STROBE_LOW - 1);
          w_half_nx  = ~r_half;
          if (r_half) begin
            w_words_nx = r_words - 8'd1;
            if (r_write) begin
              w_ack      = 1'b1;
              w_shift_nx = bus.wdata;
            end
          end
        end
      end
      ST_FINISH: if (w_zero) begin
        w_state_nx = ST_IDLE;
        w_finish   = 1'b1;
      end
      default: w_state_nx = ST_IDLE;
    endcase

    // Pins are derived from next-cycle state so they register alongside it
    w_mode_nx       = state_mode(w_state_nx);
    w_strobe_nx     = (w_state_nx == ST_STROBE_LOW);
    w_data_phase_nx = (w_state_nx == ST_SETTLE) || (w_state_nx == ST_STROBE_LOW) ||
                      (w_state_nx == ST_STROBE_HIGH);
    w_ad_oe_nx      = (w_state_nx == ST_ADDR_HIGH) || (w_state_nx == ST_ADDR_LOW) ||
                      (w_write_nx && w_data_phase_nx);
    if (w_state_nx == ST_ADDR_HIGH)     w_ad_nx = w_addr_nx[31:16];
    else if (w_state_nx == ST_ADDR_LOW) w_ad_nx = w_addr_nx[15:0];
    else if (w_half_nx)                 w_ad_nx = w_shift_nx[15:0];
    else                                w_ad_nx = w_shift_nx[31:16];
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_shift   <= '0;
      r_words   <= '0;
      r_half    <= 1'b0;
      r_write   <= 1'b0;
      r_hold    <= '0;
      r_rdata   <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_aleh    <= 1'b1;
      r_alel    <= 1'b0;
      r_read_n  <= 1'b1;
      r_write_n <= 1'b1;
      r_ad_oe   <= 1'b0;
      r_ad_out  <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_addr    <= w_addr_nx;
      r_shift   <= w_shift_nx;
      r_words   <= w_words_nx;
      r_half    <= w_half_nx;
      r_write   <= w_write_nx;
      r_valid   <= w_sample && r_half;
      r_done    <= w_finish;
      if (w_sample && !r_half) r_hold  <= io_n64_pi_ad;
      if (w_sample && r_half)  r_rdata <= {r_hold, io_n64_pi_ad};
      r_aleh    <= w_mode_nx[1];
      r_alel    <= w_mode_nx[0];
      r_read_n  <= !(w_strobe_nx && !w_write_nx);
      r_write_n <= !(w_strobe_nx && w_write_nx);
      r_ad_oe   <= w_ad_oe_nx;
      r_ad_out  <= w_ad_nx;
    end
  end

  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.done       = r_done;
  assign bus.data_ack   = w_ack && i_reset_n;
  assign bus.rdata      = r_rdata;
  assign bus.data_valid = r_valid;

  assign o_n64_pi_aleh  = r_aleh;
  assign o_n64_pi_alel  = r_alel;
  assign o_n64_pi_read  = r_read_n;
  assign o_n64_pi_write = r_write_n;
  assign io_n64_pi_ad   = r_ad_oe ? r_ad_out : 16'hzzzz;

endmodule

// File: tb/tb_n64_pi_host.sv
// Scoreboard bench for n64_pi_host with a simple cartridge-side target model on the PI pins.
module tb_n64_pi_host;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wire        aleh, alel, pi_read, pi_write;
  wire [15:0] pi_ad;

  n64_pi_host_if bus();

  n64_pi_host dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .bus            (bus),
    .o_n64_pi_aleh  (aleh),
    .o_n64_pi_alel  (alel),
    .o_n64_pi_read  (pi_read),
    .o_n64_pi_write (pi_write),
    .io_n64_pi_ad   (pi_ad)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [15:0] addr_hi_q[$], addr_lo_q[$], wr_hw_q[$], rd_hw_q[$];
  logic [31:0] rd_word_q[$], wq[$];
  logic [1:0]  mode_log[$];

  // Target: drives a queued halfword while READ is low; a keeper value marks
  // cycles where the host must have released AD.
  logic [15:0] tgt_val = 16'h0;
  logic        rd_burst = 1'b0;
  always @(negedge pi_read) tgt_val = (rd_hw_q.size() > 0) ? rd_hw_q.pop_front() : 16'hFFFF;
  wire keep_en = (aleh & ~alel) | (rd_burst & ~aleh & ~alel & pi_read);
  assign pi_ad = ~pi_read ? tgt_val : (keep_en ? 16'h5A5A : 16'hzzzz);

  logic       mon_on = 1'b0;
  logic [1:0] prev_mode = 2'b10;
  logic       prev_read = 1'b1, prev_write = 1'b1;
  int rd_pulses = 0, wr_pulses = 0, acks = 0, valids = 0, dones = 0;
  int keep_bad = 0, unexpected = 0;

  always @(negedge clk) begin
    logic [1:0] m;
    m = {aleh, alel};
    if (mon_on) begin
      if (m != prev_mode) begin
        mode_log.push_back(m);
        if (m == 2'b11) begin
          if (addr_hi_q.size() > 0) check("addr_high_phase", pi_ad, addr_hi_q.pop_front());
          else unexpected++;
        end
        if (m == 2'b01) begin
          if (addr_lo_q.size() > 0) check("addr_low_phase", pi_ad, addr_lo_q.pop_front());
          else unexpected++;
        end
      end
      if (!pi_write && prev_write) begin
        wr_pulses++;
        if (wr_hw_q.size() > 0) check("write_halfword", pi_ad, wr_hw_q.pop_front());
        else unexpected++;
      end
      if (!pi_read && prev_read) rd_pulses++;
      if (bus.data_ack) acks++;
      if (bus.data_valid) begin
        valids++;
        if (rd_word_q.size() > 0) check("read_word", bus.rdata, rd_word_q.pop_front());
        else unexpected++;
      end
      if (bus.done) dones++;
      if (keep_en && pi_ad !== 16'h5A5A) keep_bad++;
    end
    prev_mode  = m;
    prev_read  = pi_read;
    prev_write = pi_write;
  end

  // Upstream write source: next word is presented after each acknowledged cycle
  initial begin
    logic fa;
    bus.wdata = 32'h0;
    forever begin
      @(negedge clk);
      fa = bus.data_ack;
      @(posedge clk);
      #2;
      if (fa && wq.size() > 0) void'(wq.pop_front());
      bus.wdata = (wq.size() > 0) ? wq[0] : 32'h0;
    end
  end

  task automatic do_burst(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    @(posedge clk); #1;
    bus.write   = wr;
    bus.address = addr;
    bus.length  = len;
    bus.request = 1'b1;
    @(posedge clk); #1;
    bus.request = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < maxc);
    check({name, "_done_seen"}, {31'b0, bus.done}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  logic [1:0] exp_modes [4];
  int b_rd, b_wr, b_ack, b_val, b_done, n;

  initial begin
    exp_modes = '{2'b11, 2'b01, 2'b00, 2'b10};
    bus.request = 1'b0;
    bus.write   = 1'b0;
    bus.address = 32'h0;
    bus.length  = 8'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_aleh", {31'b0, aleh}, 32'd1);
    check("rst_alel", {31'b0, alel}, 32'd0);
    check("rst_read", {31'b0, pi_read}, 32'd1);
    check("rst_write", {31'b0, pi_write}, 32'd1);
    check("rst_ad_released", {16'b0, pi_ad}, 32'h5A5A);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_valid", {31'b0, bus.data_valid}, 32'd0);
    check("rst_ack", {31'b0, bus.data_ack}, 32'd0);
    check("rst_rdata", bus.rdata, 32'h0);
    mon_on = 1'b1;

    // Single-word read
    b_rd = rd_pulses; b_val = valids; b_done = dones;
    mode_log.delete();
    rd_burst = 1'b1;
    addr_hi_q.push_back(16'h1000); addr_lo_q.push_back(16'h0000);
    rd_hw_q.push_back(16'hDEAD); rd_hw_q.push_back(16'hBEEF);
    rd_word_q.push_back(32'hDEADBEEF);
    do_burst(1'b0, 32'h1000_0000, 8'd0);
    wait_done("t1", 400);
    repeat (2) @(negedge clk);
    check("t1_read_pulses", rd_pulses - b_rd, 2);
    check("t1_valids", valids - b_val, 1);
    check("t1_dones", dones - b_done, 1);
    check("t1_mode_count", mode_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < mode_log.size()) check("t1_mode_seq", {30'b0, mode_log[i]}, {30'b0, exp_modes[i]});

    // Two-word write
    b_rd = rd_pulses; b_wr = wr_pulses; b_ack = acks; b_done = dones;
    rd_burst = 1'b0;
    addr_hi_q.push_back(16'h1000); addr_lo_q.push_back(16'h0002);
    wr_hw_q.push_back(16'h1122); wr_hw_q.push_back(16'h3344);
    wr_hw_q.push_back(16'h5566); wr_hw_q.push_back(16'h7788);
    wq.push_back(32'h11223344); wq.push_back(32'h55667788);
    @(negedge clk);
    do_burst(1'b1, 32'h1000_0002, 8'd1);
    wait_done("t2", 600);
    repeat (2) @(negedge clk);
    check("t2_write_pulses", wr_pulses - b_wr, 4);
    check("t2_acks", acks - b_ack, 2);
    check("t2_read_pulses", rd_pulses - b_rd, 0);
    check("t2_dones", dones - b_done, 1);

    // 256-word read
    b_rd = rd_pulses; b_val = valids; b_done = dones;
    rd_burst = 1'b1;
    addr_hi_q.push_back(16'h1000); addr_lo_q.push_back(16'h0400);
    for (int k = 0; k < 512; k++) rd_hw_q.push_back(16'h8000 | 16'(k));
    for (int i = 0; i < 256; i++) rd_word_q.push_back({16'h8000 | 16'(2*i), 16'h8000 | 16'(2*i+1)});
    do_burst(1'b0, 32'h1000_0400, 8'd255);
    wait_done("t3", 9000);
    repeat (2) @(negedge clk);
    check("t3_read_pulses", rd_pulses - b_rd, 512);
    check("t3_valids", valids - b_val, 256);
    check("t3_dones", dones - b_done, 1);

    // Request held across a burst: second burst only after done
    b_rd = rd_pulses; b_val = valids; b_done = dones;
    for (int i = 0; i < 2; i++) begin
      addr_hi_q.push_back(16'h1000); addr_lo_q.push_back(16'h0100);
    end
    rd_hw_q.push_back(16'hCAFE); rd_hw_q.push_back(16'hF00D);
    rd_hw_q.push_back(16'h1234); rd_hw_q.push_back(16'h5678);
    rd_word_q.push_back(32'hCAFEF00D); rd_word_q.push_back(32'h12345678);
    @(posedge clk); #1;
    bus.write = 1'b0; bus.address = 32'h1000_0100; bus.length = 8'd0; bus.request = 1'b1;
    wait_done("t4a", 400);
    check("t4_busy_at_done", {31'b0, bus.busy}, 32'd0);
    @(posedge clk); #1 bus.request = 1'b0;
    @(negedge clk);
    check("t4_restart_busy", {31'b0, bus.busy}, 32'd1);
    check("t4_restart_mode", {30'b0, aleh, alel}, 32'd3);
    wait_done("t4b", 400);
    repeat (2) @(negedge clk);
    check("t4_dones", dones - b_done, 2);
    check("t4_read_pulses", rd_pulses - b_rd, 4);
    check("t4_valids", valids - b_val, 2);

    // Reset during STROBE_LOW of word 3
    b_rd = rd_pulses; b_val = valids; b_done = dones;
    addr_hi_q.push_back(16'h1000); addr_lo_q.push_back(16'h0200);
    for (int k = 0; k < 7; k++) rd_hw_q.push_back(16'h0100 | 16'(k));
    rd_word_q.push_back(32'h01000101); rd_word_q.push_back(32'h01020103);
    rd_word_q.push_back(32'h01040105);
    do_burst(1'b0, 32'h1000_0200, 8'd5);
    n = 0;
    while (!(rd_pulses - b_rd == 7 && !pi_read) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_word3", rd_pulses - b_rd, 7);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t5_mode", {30'b0, aleh, alel}, 32'd2);
    check("t5_read", {31'b0, pi_read}, 32'd1);
    check("t5_ad_released", {16'b0, pi_ad}, 32'h5A5A);
    check("t5_busy", {31'b0, bus.busy}, 32'd0);
    repeat (60) @(negedge clk);
    check("t5_no_done", dones - b_done, 0);
    check("t5_valids", valids - b_val, 3);
    check("t5_hw_consumed", rd_hw_q.size(), 0);

    // Odd address: bit 0 forced low on the bus
    b_val = valids; b_done = dones;
    addr_hi_q.push_back(16'h1000); addr_lo_q.push_back(16'h0000);
    rd_hw_q.push_back(16'h0001); rd_hw_q.push_back(16'h0002);
    rd_word_q.push_back(32'h00010002);
    do_burst(1'b0, 32'h1000_0001, 8'd0);
    wait_done("t6", 400);
    repeat (2) @(negedge clk);
    check("t6_valids", valids - b_val, 1);
    check("t6_dones", dones - b_done, 1);

    check("end_addr_hi_left", addr_hi_q.size(), 0);
    check("end_addr_lo_left", addr_lo_q.size(), 0);
    check("end_wr_hw_left", wr_hw_q.size(), 0);
    check("end_rd_word_left", rd_word_q.size(), 0);
    check("end_unexpected_events", unexpected, 0);
    check("end_ad_not_released", keep_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
